// File: rtl/io_ctrl_pkg.sv
// rtl/io_ctrl_pkg.sv - shared constants for the I/O flag and interrupt controller
// Purpose: io_bits positions of the six register-I/O instructions, the default
//          character width, and the reset values of the handshake/interrupt flags.
// Ports:   none (package).
package io_ctrl_pkg;

  // Bit positions inside io_bits (IR[11:6])
  localparam int IO_INP = 5;
  localparam int IO_OUT = 4;
  localparam int IO_SKI = 3;
  localparam int IO_SKO = 2;
  localparam int IO_ION = 1;
  localparam int IO_IOF = 0;

  localparam int CW_DEFAULT = 8;

  // Flag values after reset: no input character held, output side idle
  localparam logic FGI_RST = 1'b0;
  localparam logic FGO_RST = 1'b1;
  localparam logic IEN_RST = 1'b0;
  localparam logic R_RST   = 1'b0;

endpackage

// File: rtl/io_out_fifo.sv
// rtl/io_out_fifo.sv - synchronous output character buffer
// Purpose: DEPTH-entry FIFO (DEPTH a power of two, >= 2). A push while full and a
//          pop while empty are ignored; a push and pop in the same cycle both happen.
// Ports:   clk, reset (sync, active-high); push/push_data write side;
//          pop read side; full, empty status; head = oldest entry.
module io_out_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage is not reset; empty/full gate every use of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_flag_ctrl.sv
// rtl/io_flag_ctrl.sv - INPR/OUTR, FGI/FGO, IEN and R controller for the basic computer
// Purpose: executes INP/OUT/SKI/SKO/ION/IOF on io_en, runs the byte-wide device
//          handshakes, and raises R at instruction boundaries.
// Config:  IO_OUT_FIFO_EN defined -> OUT writes an io_out_fifo of FIFO_DEPTH entries
//          and fgo means "buffer not full"; undefined -> single OUTR register.
// Ports:   clk, reset (sync, active-high)
//          io_en, io_bits[5:0], ac_lo       : instruction strobe, decoded bits, AC source
//          inpr, ac_ld_inpr, skip           : INPR value, AC-load pulse, PC-skip pulse
//          fgi, fgo, ien, r                 : flag state
//          seq_t012, int_done               : sequence-counter phase, end of interrupt cycle
//          dev_in_valid/data, dev_in_ready  : input device handshake
//          dev_out_valid/data, dev_out_ready: output device handshake
module io_flag_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int CW         = CW_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          io_en,
  input  logic [5:0]    io_bits,
  input  logic [CW-1:0] ac_lo,
  output logic [CW-1:0] inpr,
  output logic          ac_ld_inpr,
  output logic          skip,
  output logic          fgi,
  output logic          fgo,
  output logic          ien,
  output logic          r,
  input  logic          seq_t012,
  input  logic          int_done,
  input  logic          dev_in_valid,
  input  logic [CW-1:0] dev_in_data,
  output logic          dev_in_ready,
  output logic          dev_out_valid,
  output logic [CW-1:0] dev_out_data,
  input  logic          dev_out_ready
);

  logic [CW-1:0] r_inpr;
  logic          r_fgi;
  logic          r_ien;
  logic          r_r;
  logic          r_skip;
  logic          r_ac_ld;
  logic          r_ovr;     // sticky: an OUT was dropped because the output side was busy

  logic w_inp, w_out, w_ski, w_sko, w_ion, w_iof;
  logic w_fgo;
  logic w_out_valid;
  logic w_in_xfer;
  logic w_out_xfer;

  assign w_inp = io_en & io_bits[IO_INP];
  assign w_out = io_en & io_bits[IO_OUT];
  assign w_ski = io_en & io_bits[IO_SKI];
  assign w_sko = io_en & io_bits[IO_SKO];
  assign w_ion = io_en & io_bits[IO_ION];
  assign w_iof = io_en & io_bits[IO_IOF];

  assign w_in_xfer  = dev_in_valid & ~r_fgi;
  assign w_out_xfer = w_out_valid & dev_out_ready;

`ifdef IO_OUT_FIFO_EN
  logic w_full;
  logic w_empty;

  io_out_fifo #(
    .W     (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_out),
    .push_data (ac_lo),
    .pop       (w_out_xfer),
    .full      (w_full),
    .empty     (w_empty),
    .head      (dev_out_data)
  );

  assign w_fgo       = ~w_full;
  assign w_out_valid = ~w_empty;
`else
  logic [CW-1:0] r_outr;
  logic          r_fgo;

  // A device transfer needs fgo=0 and an accepted OUT needs fgo=1, so the
  // two branches are never both live.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outr <= '0;
      r_fgo  <= FGO_RST;
    end else if (w_out && r_fgo) begin
      r_outr <= ac_lo;
      r_fgo  <= 1'b0;
    end else if (w_out_xfer) begin
      r_fgo  <= 1'b1;
    end
  end

  assign w_fgo        = r_fgo;
  assign w_out_valid  = ~r_fgo;
  assign dev_out_data = r_outr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inpr  <= '0;
      r_fgi   <= FGI_RST;
      r_ien   <= IEN_RST;
      r_r     <= R_RST;
      r_skip  <= 1'b0;
      r_ac_ld <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ac_ld <= w_inp;
      r_skip  <= (w_ski & r_fgi) | (w_sko & w_fgo);

      // An arriving character wins over INP; INP only ever sees fgi=1 in
      // normal use, when no transfer can be in flight.
      if (w_in_xfer) begin
        r_inpr <= dev_in_data;
        r_fgi  <= 1'b1;
      end else if (w_inp) begin
        r_fgi  <= 1'b0;
      end

      if (w_out && !w_fgo) r_ovr <= 1'b1;

      if (int_done || w_iof) r_ien <= 1'b0;
      else if (w_ion)        r_ien <= 1'b1;

      // Uses the flags as they stand before this edge.
      if (int_done)                                  r_r <= 1'b0;
      else if (r_ien && !seq_t012 && (r_fgi || w_fgo)) r_r <= 1'b1;
    end
  end

  assign inpr          = r_inpr;
  assign ac_ld_inpr    = r_ac_ld;
  assign skip          = r_skip;
  assign fgi           = r_fgi;
  assign fgo           = w_fgo;
  assign ien           = r_ien;
  assign r             = r_r;
  assign dev_in_ready  = ~r_fgi;
  assign dev_out_valid = w_out_valid;

endmodule

// File: tb/tb_io_flag_ctrl.sv
// tb/tb_io_flag_ctrl.sv - scoreboard bench for io_flag_ctrl
module tb_io_flag_ctrl;

  localparam int CW = 8;

  localparam int S_INPR  = 0;
  localparam int S_AC_LD = 1;
  localparam int S_SKIP  = 2;
  localparam int S_FGI   = 3;
  localparam int S_FGO   = 4;
  localparam int S_IEN   = 5;
  localparam int S_R     = 6;
  localparam int S_INRDY = 7;
  localparam int S_OVAL  = 8;
  localparam int S_ODATA = 9;
  localparam int S_OVR   = 10;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_en;
  logic [5:0]    io_bits;
  logic [CW-1:0] ac_lo;
  logic [CW-1:0] inpr;
  logic          ac_ld_inpr;
  logic          skip;
  logic          fgi;
  logic          fgo;
  logic          ien;
  logic          r;
  logic          seq_t012;
  logic          int_done;
  logic          dev_in_valid;
  logic [CW-1:0] dev_in_data;
  logic          dev_in_ready;
  logic          dev_out_valid;
  logic [CW-1:0] dev_out_data;
  logic          dev_out_ready;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  io_flag_ctrl #(.CW(CW), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_en         (io_en),
    .io_bits       (io_bits),
    .ac_lo         (ac_lo),
    .inpr          (inpr),
    .ac_ld_inpr    (ac_ld_inpr),
    .skip          (skip),
    .fgi           (fgi),
    .fgo           (fgo),
    .ien           (ien),
    .r             (r),
    .seq_t012      (seq_t012),
    .int_done      (int_done),
    .dev_in_valid  (dev_in_valid),
    .dev_in_data   (dev_in_data),
    .dev_in_ready  (dev_in_ready),
    .dev_out_valid (dev_out_valid),
    .dev_out_data  (dev_out_data),
    .dev_out_ready (dev_out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get(int s);
    case (s)
      S_INPR:  get = 32'(inpr);
      S_AC_LD: get = 32'(ac_ld_inpr);
      S_SKIP:  get = 32'(skip);
      S_FGI:   get = 32'(fgi);
      S_FGO:   get = 32'(fgo);
      S_IEN:   get = 32'(ien);
      S_R:     get = 32'(r);
      S_INRDY: get = 32'(dev_in_ready);
      S_OVAL:  get = 32'(dev_out_valid);
      S_ODATA: get = 32'(dev_out_data);
      S_OVR:   get = 32'(dut.r_ovr);
      default: get = 'x;
    endcase
  endfunction

  // Monitor: at each falling edge, check every record due in this cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        n_tests++;
        if (get(sbq[i].sig) !== sbq[i].val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h",
                   sbq[i].name, cyc, get(sbq[i].sig), sbq[i].val);
        end
        sbq.delete(i);
      end else if (sbq[i].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: record for cyc %0d never checked (now %0d)",
                 sbq[i].name, sbq[i].cyc, cyc);
        sbq.delete(i);
      end
    end
  end

  task automatic expect_at(input int d, input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.sig  = sig;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    io_en    = 1'b0;
    io_bits  = 6'b0;
    int_done = 1'b0;
  endtask

  task automatic strobe(input logic [5:0] b);
    io_en   = 1'b1;
    io_bits = b;
  endtask

  task automatic expect_reset_state(input int d);
    expect_at(d, S_INPR,  0, "rst_inpr");
    expect_at(d, S_FGI,   0, "rst_fgi");
    expect_at(d, S_FGO,   1, "rst_fgo");
    expect_at(d, S_IEN,   0, "rst_ien");
    expect_at(d, S_R,     0, "rst_r");
    expect_at(d, S_SKIP,  0, "rst_skip");
    expect_at(d, S_AC_LD, 0, "rst_ac_ld");
    expect_at(d, S_OVAL,  0, "rst_out_valid");
    expect_at(d, S_INRDY, 1, "rst_in_ready");
    expect_at(d, S_OVR,   0, "rst_ovr");
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    reset = 1'b1; io_en = 1'b0; io_bits = 6'b0; ac_lo = '0;
    seq_t012 = 1'b1; int_done = 1'b0;
    dev_in_valid = 1'b0; dev_in_data = '0; dev_out_ready = 1'b0;
    tick();
    expect_reset_state(0);
`ifndef IO_OUT_FIFO_EN
    expect_at(0, S_ODATA, 0, "rst_outr");
`endif
    reset = 1'b0;

    // Input character 0x41
    dev_in_valid = 1'b1; dev_in_data = 8'h41;
    expect_at(1, S_FGI,   1,     "in_fgi_set");
    expect_at(1, S_INPR,  8'h41, "in_inpr");
    expect_at(1, S_INRDY, 0,     "in_ready_low");
    tick();
    dev_in_valid = 1'b0;

    // INP
    strobe(6'b100000);
    expect_at(1, S_AC_LD, 1,     "inp_pulse");
    expect_at(1, S_INPR,  8'h41, "inp_inpr_stable");
    expect_at(1, S_FGI,   0,     "inp_fgi_clr");
    expect_at(1, S_INRDY, 1,     "inp_ready_high");
    expect_at(2, S_AC_LD, 0,     "inp_pulse_end");
    tick();
    tick();

`ifndef IO_OUT_FIFO_EN
    // OUT 0x5A while fgo=1
    ac_lo = 8'h5A; strobe(6'b010000);
    expect_at(1, S_FGO,   0,     "out_fgo_clr");
    expect_at(1, S_OVAL,  1,     "out_valid");
    expect_at(1, S_ODATA, 8'h5A, "out_data");
    tick();
    // Second OUT while busy: dropped, ovr set
    ac_lo = 8'h33; strobe(6'b010000);
    expect_at(1, S_OVR,   1,     "out_ovr");
    expect_at(1, S_ODATA, 8'h5A, "out_outr_kept");
    expect_at(1, S_FGO,   0,     "out_fgo_still0");
    tick();
    dev_out_ready = 1'b1;
    expect_at(1, S_FGO,  1, "out_done_fgo");
    expect_at(1, S_OVAL, 0, "out_done_valid");
    tick();
    dev_out_ready = 1'b0;
`else
    // Four OUTs with the device stalled fill the buffer
    for (int i = 1; i <= 4; i++) begin
      ac_lo = 8'(i); strobe(6'b010000);
      expect_at(1, S_FGO, (i == 4) ? 0 : 1, "fifo_fgo_fill");
      tick();
    end
    expect_at(0, S_OVAL,  1, "fifo_valid");
    expect_at(0, S_ODATA, 1, "fifo_head");
    ac_lo = 8'h05; strobe(6'b010000);
    expect_at(1, S_OVR, 1, "fifo_ovr");
    expect_at(1, S_FGO, 0, "fifo_fgo_full");
    tick();
    dev_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      expect_at(0, S_OVAL,  1, "fifo_drain_valid");
      expect_at(0, S_ODATA, 32'(i), "fifo_drain_data");
      if (i == 1) expect_at(1, S_FGO, 1, "fifo_fgo_after_pop");
      tick();
    end
    expect_at(0, S_OVAL, 0, "fifo_empty");
    dev_out_ready = 1'b0;
`endif

    // SKI with fgi=0
    strobe(6'b001000);
    expect_at(1, S_SKIP, 0, "ski_fgi0");
    tick();
    // Load a character, then SKI with fgi=1
    dev_in_valid = 1'b1; dev_in_data = 8'h7E;
    expect_at(1, S_FGI, 1, "in2_fgi");
    tick();
    dev_in_valid = 1'b0;
    strobe(6'b001000);
    expect_at(1, S_SKIP, 1, "ski_fgi1");
    expect_at(2, S_SKIP, 0, "ski_pulse_end");
    tick();
    tick();
    // Clear fgi, then SKI|SKO with only fgo=1
    strobe(6'b100000);
    tick();
    strobe(6'b001100);
    expect_at(1, S_SKIP, 1, "ski_sko_or");
    expect_at(2, S_SKIP, 0, "ski_sko_end");
    tick();
    tick();

    // ION, fgi rise, then r set at an instruction boundary
    strobe(6'b000010);
    expect_at(1, S_IEN, 1, "ion");
    expect_at(1, S_R,   0, "ion_r_in_t012");
    tick();
    dev_in_valid = 1'b1; dev_in_data = 8'h21;
    tick();
    dev_in_valid = 1'b0; seq_t012 = 1'b0;
    expect_at(1, S_R, 1, "r_set");
    tick();
    seq_t012 = 1'b1; int_done = 1'b1;
    expect_at(1, S_R,   0, "int_done_r");
    expect_at(1, S_IEN, 0, "int_done_ien");
    tick();
    // int_done concurrent with the set condition
    strobe(6'b000010);
    tick();
    seq_t012 = 1'b0; int_done = 1'b1;
    expect_at(1, S_R,   0, "int_done_prio_r");
    expect_at(1, S_IEN, 0, "int_done_prio_ien");
    tick();
    seq_t012 = 1'b1;
    // ION+IOF together: IOF wins
    strobe(6'b000010);
    tick();
    strobe(6'b000011);
    expect_at(1, S_IEN, 0, "iof_wins");
    tick();
    // io_en with no bits is a no-op
    strobe(6'b000000);
    expect_at(1, S_SKIP,  0, "noop_skip");
    expect_at(1, S_AC_LD, 0, "noop_ac_ld");
    expect_at(1, S_FGI,   1, "noop_fgi");
    expect_at(1, S_FGO,   1, "noop_fgo");
    tick();

    // Reset in the middle of an output handshake
    ac_lo = 8'h99; strobe(6'b010000);
    tick();
    reset = 1'b1; dev_out_ready = 1'b1; dev_in_valid = 1'b1; dev_in_data = 8'hC3;
    strobe(6'b101000);
    expect_reset_state(1);
`ifndef IO_OUT_FIFO_EN
    expect_at(1, S_ODATA, 0, "rst_mid_outr");
`endif
    tick();
    reset = 1'b0; dev_out_ready = 1'b0; dev_in_valid = 1'b0;
    tick();
    tick();

    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
